// File: rtl/cmp_sort_engine.sv
// cmp_sort_engine: in-place bubble sort over a small flop array, using one
// shared 32-bit comparator. Each compare takes one cycle and each swap adds one
// more. The host loads words, pulses start and reads the results after done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | host may write the array; start latches modes and begins
// S_CMP  | compare mem[i] against mem[i+1]; advance unless a swap is needed
// S_SWAP | exchange mem[i] and mem[i+1], count the swap, then advance
// S_DONE | one-cycle done pulse, then back to S_IDLE

module cmp_sort_engine #(
    parameter int N = 8,
    parameter int W = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    input  logic          signed_mode,
    input  logic          descend,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic [7:0]    swap_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_SWAP, S_DONE} state_t;

    localparam logic [AW:0] N_LIM = (AW+1)'(N);

    state_t        state, state_nx;
    logic [W-1:0]  mem [N];
    logic [AW-1:0] i_q, pass_q, i_nx1;
    logic          pass_swapped, sm_q, de_q;
    logic [W-1:0]  op_a, op_b;
    logic          lt, gt, out_of_order;
    logic          adv_go, last_in_pass, finish;

    assign i_nx1 = i_q + AW'(1);
    assign op_a  = mem[i_q];
    assign op_b  = mem[i_nx1];

    // Shared comparator: signed or unsigned according to the mode latched at start
    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        if (sm_q) begin
            lt = $signed(op_a) < $signed(op_b);
            gt = $signed(op_a) > $signed(op_b);
        end else begin
            lt = op_a < op_b;
            gt = op_a > op_b;
        end
    end

    // Equal words are never out of order, which keeps the sort stable
    assign out_of_order = de_q ? lt : gt;

    // Advance decision, shared by the CMP and SWAP exits
    always_comb begin
        adv_go       = (state == S_SWAP) || ((state == S_CMP) && !out_of_order);
        last_in_pass = int'(i_q) >= (N - 2 - int'(pass_q));
        finish       = (int'(pass_q) == N - 2) || !(pass_swapped || (state == S_SWAP));
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_CMP;
            S_CMP: begin
                if (out_of_order)      state_nx = S_SWAP;
                else if (last_in_pass) state_nx = finish ? S_DONE : S_CMP;
                else                   state_nx = S_CMP;
            end
            S_SWAP: begin
                if (last_in_pass) state_nx = finish ? S_DONE : S_CMP;
                else              state_nx = S_CMP;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Array, indices, swap counter and latched modes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) mem[k] <= '0;
            i_q          <= '0;
            pass_q       <= '0;
            pass_swapped <= 1'b0;
            sm_q         <= 1'b0;
            de_q         <= 1'b0;
            swap_cnt     <= '0;
        end else begin
            if (state == S_IDLE) begin
                // The write lands in the same edge as start, so the sort sees it
                if (wr_en && ({1'b0, wr_addr} < N_LIM)) mem[wr_addr] <= wr_data;
                if (start) begin
                    sm_q         <= signed_mode;
                    de_q         <= descend;
                    i_q          <= '0;
                    pass_q       <= '0;
                    pass_swapped <= 1'b0;
                    swap_cnt     <= '0;
                end
            end
            if (state == S_SWAP) begin
                mem[i_q]     <= op_b;
                mem[i_nx1]   <= op_a;
                pass_swapped <= 1'b1;
                if (swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;
            end
            if (adv_go) begin
                if (!last_in_pass) begin
                    i_q <= i_nx1;
                end else if (!finish) begin
                    pass_q       <= pass_q + AW'(1);
                    i_q          <= '0;
                    pass_swapped <= 1'b0;
                end
            end
        end
    end

    // Combinational read port; out-of-range indices read as zero
    assign rd_data = ({1'b0, rd_addr} < N_LIM) ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_cmp_sort_engine.sv
// Scoreboard bench for cmp_sort_engine (N=8). The driver loads words, starts a
// sort and pushes the reference result; the monitor pops and compares on each
// done pulse (or on an explicit probe after a reset).
`timescale 1ns/10ps

module tb_cmp_sort_engine;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic        descend = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy, done;
    logic [7:0]  swap_cnt;
    logic        probe = 1'b0;

    typedef struct packed {
        logic [7:0][31:0] arr;
        logic [7:0]       swaps;
        logic [15:0]      cycles;
        logic             chk_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    cmp_sort_engine #(.N(N), .W(32)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .signed_mode(signed_mode), .descend(descend),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic bit greater(input logic [31:0] x, input logic [31:0] y, input bit sm);
        return sm ? ($signed(x) > $signed(y)) : (x > y);
    endfunction

    // Reference: bubble sort with early exit when a pass makes no swap
    function automatic exp_t model(input logic [7:0][31:0] d, input bit sm, input bit de);
        exp_t e;
        int comps = 0;
        int sw = 0;
        logic [31:0] t;
        for (int p = 0; p <= N - 2; p++) begin
            bit any = 1'b0;
            for (int j = 0; j <= N - 2 - p; j++) begin
                bit ooo;
                comps++;
                ooo = de ? greater(d[j+1], d[j], sm) : greater(d[j], d[j+1], sm);
                if (ooo) begin
                    t = d[j]; d[j] = d[j+1]; d[j+1] = t;
                    sw++;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
        e.arr        = d;
        e.swaps      = (sw > 255) ? 8'hFF : 8'(sw);
        e.cycles     = 16'(comps + sw + 1);
        e.chk_cycles = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sort(input logic [7:0][31:0] d, input bit sm, input bit de,
                            input bit combo, input bit disturb);
        int cnt;
        exp_q.push_back(model(d, sm, de));
        for (int k = 0; k < N; k++) begin
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = d[k];
            if (combo && k == N - 1) begin
                start = 1'b1; signed_mode = sm; descend = de;
            end
            tick();
        end
        wr_en = 1'b0;
        if (!combo) begin
            start = 1'b1; signed_mode = sm; descend = de;
            tick();
        end
        start = 1'b0;
        check("busy_rise", {31'b0, busy}, 32'd1);
        cnt = 0;
        while (busy && cnt < 300) begin
            if (disturb && (cnt == 1 || cnt == 3)) begin
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = $urandom;
                start = 1'b1; signed_mode = ~sm; descend = ~de;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            tick();
            cnt++;
        end
        wr_en = 1'b0; start = 1'b0;
        if (cnt >= 300) check("busy_timeout", 32'(cnt), 32'd0);
        tick();
        tick();
    endtask

    task automatic probe_zero();
        exp_t e;
        e.arr = '0; e.swaps = '0; e.cycles = '0; e.chk_cycles = 1'b0;
        exp_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
        tick();
    endtask

    // Monitor: count busy run length, compare on done or probe
    initial begin : monitor
        int run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) run++; else run = 0;
            if (done || probe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("swap_cnt", {24'b0, swap_cnt}, {24'b0, e.swaps});
                    if (e.chk_cycles) check("busy_cycles", 32'(run), {16'b0, e.cycles});
                    for (int k = 0; k < N; k++) begin
                        rd_addr = 3'(k);
                        #0.2;
                        check($sformatf("mem[%0d]", k), rd_data, e.arr[k]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_word(input int kind);
        logic [31:0] pick [5];
        pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'h7FFFFFFF;
        pick[3] = 32'h80000000; pick[4] = 32'hFFFFFFFF;
        case (kind)
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 3));
            default: return pick[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin : driver
        logic [7:0][31:0] d;

        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_swap_cnt", {24'b0, swap_cnt}, 32'd0);
        rstn = 1'b1;
        tick();
        probe_zero();

        // Reverse order, unsigned ascending
        for (int k = 0; k < N; k++) d[k] = 32'(7 - k);
        run_sort(d, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sign-sensitive data, signed then unsigned
        d[0] = 32'd5; d[1] = 32'hFFFFFFFF; d[2] = 32'h80000000; d[3] = 32'd1;
        for (int k = 4; k < N; k++) d[k] = 32'h7FFFFFFF;
        run_sort(d, 1'b1, 1'b0, 1'b0, 1'b0);
        run_sort(d, 1'b0, 1'b0, 1'b1, 1'b0);

        // Already sorted
        for (int k = 0; k < N; k++) d[k] = 32'(k);
        run_sort(d, 1'b0, 1'b0, 1'b0, 1'b0);

        // Duplicates, descending
        d = '0; d[0] = 32'd3; d[1] = 32'd3; d[2] = 32'd1;
        run_sort(d, 1'b0, 1'b1, 1'b0, 1'b0);

        // Disturbed sort: writes, starts and mode changes while busy
        for (int k = 0; k < N; k++) d[k] = $urandom;
        run_sort(d, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset asserted during the first SWAP cycle
        for (int k = 0; k < N; k++) begin
            wr_en = 1'b1; wr_addr = 3'(k); wr_data = 32'(7 - k);
            tick();
        end
        wr_en = 1'b0; start = 1'b1; signed_mode = 1'b0; descend = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        probe_zero();

        // Randomized sorts
        for (int r = 0; r < 20; r++) begin
            int kind = $urandom_range(0, 2);
            for (int k = 0; k < N; k++) d[k] = rand_word(kind);
            run_sort(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
